wavepool_instr_queue: RTL and testbench

WAVEPOOL_INSTR_QUEUE -- requirements
Module: wavepool_instr_queue

---
 rtl/wavepool_instr_queue.sv | 127 ++++++++++++
 tb/tb_wavepool_instr_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavepool_instr_queue.sv
// Wavepool instruction queue: a 4-entry circular FIFO between fetch and decode.
// Each entry carries the instruction and its wavefront's register/LDS bases, plus
// a live bit. A recover kills every queued instruction of one wavefront by
// clearing live bits. Dead entries still occupy a slot until they reach the head,
// where they drain at one per cycle without being presented downstream.
module wavepool_instr_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instr,
    input  logic [5:0]  fetch_wfid,
    input  logic [9:0]  fetch_vgpr_base,
    input  logic [8:0]  fetch_sgpr_base,
    input  logic [15:0] fetch_lds_base,
    output logic        fetch_ready,
    input  logic        decode_ready,
    input  logic        issue_recover_en,
    input  logic [5:0]  issue_recover_wfid,
    output logic        wave_instr_valid,
    output logic [31:0] wave_instr_pc,
    output logic [31:0] wave_instr,
    output logic [5:0]  wave_wfid,
    output logic [9:0]  wave_vgpr_base,
    output logic [8:0]  wave_sgpr_base,
    output logic [15:0] wave_lds_base,
    output logic [2:0]  queue_count
);

    logic [31:0] pc_reg    [4];
    logic [31:0] instr_reg [4];
    logic [5:0]  wfid_reg  [4];
    logic [9:0]  vgpr_reg  [4];
    logic [8:0]  sgpr_reg  [4];
    logic [15:0] lds_reg   [4];
    logic [3:0]  live_reg;
    logic [1:0]  head_reg;
    logic [1:0]  tail_reg;
    logic [2:0]  count_reg;

    logic [3:0]  occupied;
    logic [3:0]  kill;
    logic        not_empty;
    logic        head_killed;
    logic        head_dead;
    logic        push;
    logic        pop;
    logic        push_live;

    // Per-slot occupancy (distance from head below count) and recover match.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            localparam logic [1:0] SLOT = 2'(gi);
            logic [1:0] offset;
            assign offset       = SLOT - head_reg;
            assign occupied[gi] = {1'b0, offset} < count_reg;
            assign kill[gi]     = issue_recover_en & occupied[gi]
                                  & (wfid_reg[gi] == issue_recover_wfid);
        end
    endgenerate

    assign not_empty   = (count_reg != 3'd0);
    // A head killed this cycle is treated exactly like an already-dead head.
    assign head_killed = issue_recover_en & not_empty
                         & (wfid_reg[head_reg] == issue_recover_wfid);
    assign head_dead   = not_empty & (~live_reg[head_reg] | head_killed);

    // Accept decision uses the registered count only, so a full queue never
    // accepts even when it pops in the same cycle.
    assign fetch_ready      = (count_reg != 3'd4);
    assign push             = fetch_valid & fetch_ready;
    assign push_live        = ~(issue_recover_en & (fetch_wfid == issue_recover_wfid));
    assign wave_instr_valid = not_empty & live_reg[head_reg] & decode_ready & ~head_killed;
    assign pop              = wave_instr_valid | head_dead;

    assign queue_count    = count_reg;
    assign wave_instr_pc  = not_empty ? pc_reg[head_reg]    : 32'd0;
    assign wave_instr     = not_empty ? instr_reg[head_reg] : 32'd0;
    assign wave_wfid      = not_empty ? wfid_reg[head_reg]  : 6'd0;
    assign wave_vgpr_base = not_empty ? vgpr_reg[head_reg]  : 10'd0;
    assign wave_sgpr_base = not_empty ? sgpr_reg[head_reg]  : 9'd0;
    assign wave_lds_base  = not_empty ? lds_reg[head_reg]   : 16'd0;

    // Entry storage: write the tail on push, otherwise apply recover kills.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                pc_reg[i]    <= '0;
                instr_reg[i] <= '0;
                wfid_reg[i]  <= '0;
                vgpr_reg[i]  <= '0;
                sgpr_reg[i]  <= '0;
                lds_reg[i]   <= '0;
            end
            live_reg <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push && (tail_reg == 2'(i))) begin
                    pc_reg[i]    <= fetch_pc;
                    instr_reg[i] <= fetch_instr;
                    wfid_reg[i]  <= fetch_wfid;
                    vgpr_reg[i]  <= fetch_vgpr_base;
                    sgpr_reg[i]  <= fetch_sgpr_base;
                    lds_reg[i]   <= fetch_lds_base;
                    live_reg[i]  <= push_live;
                end else if (kill[i]) begin
                    live_reg[i]  <= 1'b0;
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + {1'b0, pop};
            tail_reg  <= tail_reg + {1'b0, push};
            count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_wavepool_instr_queue.sv
// Bench for wavepool_instr_queue: a queue-of-entries reference model predicts
// the outputs every cycle; directed scenarios add explicit value checks.
module tb_wavepool_instr_queue;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [5:0]  fetch_wfid;
    logic [9:0]  fetch_vgpr_base;
    logic [8:0]  fetch_sgpr_base;
    logic [15:0] fetch_lds_base;
    logic        fetch_ready;
    logic        decode_ready;
    logic        issue_recover_en;
    logic [5:0]  issue_recover_wfid;
    logic        wave_instr_valid;
    logic [31:0] wave_instr_pc;
    logic [31:0] wave_instr;
    logic [5:0]  wave_wfid;
    logic [9:0]  wave_vgpr_base;
    logic [8:0]  wave_sgpr_base;
    logic [15:0] wave_lds_base;
    logic [2:0]  queue_count;

    int tests = 0;
    int fails = 0;

    wavepool_instr_queue dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .fetch_instr        (fetch_instr),
        .fetch_wfid         (fetch_wfid),
        .fetch_vgpr_base    (fetch_vgpr_base),
        .fetch_sgpr_base    (fetch_sgpr_base),
        .fetch_lds_base     (fetch_lds_base),
        .fetch_ready        (fetch_ready),
        .decode_ready       (decode_ready),
        .issue_recover_en   (issue_recover_en),
        .issue_recover_wfid (issue_recover_wfid),
        .wave_instr_valid   (wave_instr_valid),
        .wave_instr_pc      (wave_instr_pc),
        .wave_instr         (wave_instr),
        .wave_wfid          (wave_wfid),
        .wave_vgpr_base     (wave_vgpr_base),
        .wave_sgpr_base     (wave_sgpr_base),
        .wave_lds_base      (wave_lds_base),
        .queue_count        (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: valid, ready, count, then head data fields.
    logic [109:0] obs;
    assign obs = {wave_instr_valid, fetch_ready, queue_count, wave_instr_pc, wave_instr,
                  wave_wfid, wave_vgpr_base, wave_sgpr_base, wave_lds_base};

    localparam logic [109:0] RST_VEC = {2'b01, 108'd0};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  wfid;
        logic [9:0]  vb;
        logic [8:0]  sb;
        logic [15:0] lb;
        logic        live;
    } ent_t;

    ent_t q[$];

    task automatic set_fetch(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [5:0] wf);
        fetch_valid     = v;
        fetch_pc        = pc;
        fetch_instr     = ins;
        fetch_wfid      = wf;
        fetch_vgpr_base = 10'($urandom);
        fetch_sgpr_base = 9'($urandom);
        fetch_lds_base  = 16'($urandom);
    endtask

    // Wait for the sampling point and compute what the outputs must be now.
    task automatic predict(output logic [109:0] e);
        ent_t h;
        logic v;
        logic [2:0] c;
        @(negedge clk);
        h = '0;
        v = 1'b0;
        c = 3'(q.size());
        if (q.size() > 0) begin
            h = q[0];
            v = h.live && decode_ready && !(issue_recover_en && h.wfid == issue_recover_wfid);
        end
        e = {v, (c != 3'd4), c, h.pc, h.instr, h.wfid, h.vb, h.sb, h.lb};
    endtask

    // Apply this cycle's inputs to the model, then advance past the clock edge.
    task automatic commit();
        int cnt;
        logic killed;
        ent_t n;
        cnt = q.size();
        if (cnt > 0) begin
            killed = issue_recover_en && (q[0].wfid == issue_recover_wfid);
            if (!q[0].live || killed || decode_ready) q.delete(0);
        end
        if (issue_recover_en) begin
            foreach (q[i]) if (q[i].wfid == issue_recover_wfid) q[i].live = 1'b0;
        end
        if (fetch_valid && cnt != 4) begin
            n = {fetch_pc, fetch_instr, fetch_wfid, fetch_vgpr_base, fetch_sgpr_base,
                 fetch_lds_base, !(issue_recover_en && fetch_wfid == issue_recover_wfid)};
            q.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        decode_ready = 1'b1;
        issue_recover_en = 1'b0;
        issue_recover_wfid = 6'd0;
        set_fetch(1'b1, 32'h44, 32'h55, 6'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (obs !== RST_VEC) begin
                fails++;
                $display("FAIL reset_state cyc%0d got=%h exp=%h", i, obs, RST_VEC);
            end
            tests++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_valid = 1'b0;
        q.delete();
        $display("[TB] reset checked");
    endtask

    task automatic test_single_push();
        logic [109:0] e;
        decode_ready = 1'b1;
        set_fetch(1'b1, 32'h100, 32'hBF810000, 6'd5);
        predict(e);
        if (obs !== e) begin fails++; $display("FAIL single_push0 got=%h exp=%h", obs, e); end
        tests++;
        commit();
        fetch_valid = 1'b0;
        predict(e);
        if (obs !== e) begin fails++; $display("FAIL single_push1 got=%h exp=%h", obs, e); end
        tests++;
        if (!(wave_instr_valid === 1'b1 && wave_instr_pc === 32'h100 &&
              wave_instr === 32'hBF810000 && wave_wfid === 6'd5)) begin
            fails++;
            $display("FAIL single_push_out got v=%b pc=%h ins=%h wf=%0d exp v=1 pc=100 ins=bf810000 wf=5",
                     wave_instr_valid, wave_instr_pc, wave_instr, wave_wfid);
        end
        tests++;
        commit();
        predict(e);
        if (queue_count !== 3'd0) begin
            fails++;
            $display("FAIL single_push_drain got=%0d exp=0", queue_count);
        end
        tests++;
        commit();
        $display("[TB] single push checked");
    endtask

    task automatic test_fill();
        logic [109:0] e;
        logic [31:0] pcs [4];
        decode_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_fetch(1'b1, $urandom, $urandom, 6'($urandom));
            if (i < 4) pcs[i] = fetch_pc;
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL fill_push%0d got=%h exp=%h", i, obs, e); end
            tests++;
            commit();
        end
        fetch_valid = 1'b0;
        predict(e);
        if (queue_count !== 3'd4 || fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", queue_count, fetch_ready);
        end
        tests++;
        commit();
        decode_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL fill_drain%0d got=%h exp=%h", i, obs, e); end
            tests++;
            if (wave_instr_valid !== 1'b1 || wave_instr_pc !== pcs[i]) begin
                fails++;
                $display("FAIL fill_order%0d got v=%b pc=%h exp v=1 pc=%h", i, wave_instr_valid, wave_instr_pc, pcs[i]);
            end
            tests++;
            commit();
        end
        predict(e);
        if (fetch_ready !== 1'b1 || queue_count !== 3'd0) begin
            fails++;
            $display("FAIL fill_empty got rdy=%b cnt=%0d exp rdy=1 cnt=0", fetch_ready, queue_count);
        end
        tests++;
        commit();
        $display("[TB] fill/drop/drain checked");
    endtask

    task automatic test_wrap();
        logic [109:0] e;
        int n_out = 0;
        decode_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            set_fetch(i < 10, $urandom, $urandom, 6'($urandom));
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL wrap cyc%0d got=%h exp=%h", i, obs, e); end
            tests++;
            if (wave_instr_valid === 1'b1) n_out++;
            commit();
        end
        fetch_valid = 1'b0;
        if (n_out != 10) begin fails++; $display("FAIL wrap_count got=%0d exp=10", n_out); end
        tests++;
        $display("[TB] wrap checked");
    endtask

    task automatic test_recover();
        logic [109:0] e;
        logic [5:0] wfs [4];
        logic [5:0] seen[$];
        wfs[0] = 6'd2; wfs[1] = 6'd7; wfs[2] = 6'd2; wfs[3] = 6'd3;
        decode_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_fetch(1'b1, $urandom, $urandom, wfs[i]);
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL recover_fill%0d got=%h exp=%h", i, obs, e); end
            tests++;
            commit();
        end
        fetch_valid = 1'b0;
        decode_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue_recover_en = (i == 0);
            issue_recover_wfid = 6'd2;
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL recover_cyc%0d got=%h exp=%h", i, obs, e); end
            tests++;
            if (wave_instr_valid === 1'b1) seen.push_back(wave_wfid);
            commit();
        end
        issue_recover_en = 1'b0;
        if (seen.size() != 2 || seen[0] !== 6'd7 || seen[1] !== 6'd3) begin
            fails++;
            $display("FAIL recover_order got n=%0d exp n=2 wfids 7,3", seen.size());
        end
        tests++;
        if (queue_count !== 3'd0) begin fails++; $display("FAIL recover_empty got=%0d exp=0", queue_count); end
        tests++;
        $display("[TB] recover checked");
    endtask

    task automatic test_same_cycle();
        logic [109:0] e;
        int n_valid = 0;
        decode_ready = 1'b1;
        set_fetch(1'b1, $urandom, $urandom, 6'd9);
        issue_recover_en = 1'b1;
        issue_recover_wfid = 6'd9;
        for (int i = 0; i < 3; i++) begin
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL same_push_kill%0d got=%h exp=%h", i, obs, e); end
            tests++;
            if (wave_instr_valid === 1'b1) n_valid++;
            commit();
            fetch_valid = 1'b0;
            issue_recover_en = 1'b0;
        end
        if (n_valid != 0 || queue_count !== 3'd0) begin
            fails++;
            $display("FAIL same_push_kill_out got valids=%0d cnt=%0d exp 0,0", n_valid, queue_count);
        end
        tests++;
        decode_ready = 1'b0;
        set_fetch(1'b1, $urandom, $urandom, 6'd4);
        predict(e);
        commit();
        fetch_valid = 1'b0;
        decode_ready = 1'b1;
        issue_recover_en = 1'b1;
        issue_recover_wfid = 6'd4;
        predict(e);
        if (wave_instr_valid !== 1'b0 || obs !== e) begin
            fails++;
            $display("FAIL head_kill got=%h exp=%h", obs, e);
        end
        tests++;
        commit();
        issue_recover_en = 1'b0;
        predict(e);
        if (queue_count !== 3'd0) begin fails++; $display("FAIL head_kill_drain got=%0d exp=0", queue_count); end
        tests++;
        commit();
        $display("[TB] same-cycle recover checked");
    endtask

    task automatic test_random();
        logic [109:0] e;
        for (int i = 0; i < 400; i++) begin
            set_fetch(($urandom % 4) != 0, $urandom, $urandom, 6'($urandom % 4));
            decode_ready = ($urandom % 3) != 0;
            issue_recover_en = ($urandom % 6) == 0;
            issue_recover_wfid = 6'($urandom % 4);
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL random cyc%0d got=%h exp=%h", i, obs, e); end
            tests++;
            commit();
        end
        fetch_valid = 1'b0;
        issue_recover_en = 1'b0;
        $display("[TB] random traffic checked");
    endtask

    task automatic test_reset_mid();
        logic [109:0] e;
        int n_valid = 0;
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_fetch(1'b1, $urandom, $urandom, 6'($urandom));
            predict(e);
            commit();
        end
        fetch_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        if (obs !== RST_VEC) begin fails++; $display("FAIL reset_mid got=%h exp=%h", obs, RST_VEC); end
        tests++;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        decode_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_fetch(i == 0, $urandom, $urandom, 6'($urandom));
            predict(e);
            if (obs !== e) begin fails++; $display("FAIL reset_release%0d got=%h exp=%h", i, obs, e); end
            tests++;
            if (wave_instr_valid === 1'b1) n_valid++;
            commit();
        end
        fetch_valid = 1'b0;
        if (n_valid != 1) begin fails++; $display("FAIL reset_stale got valids=%0d exp=1", n_valid); end
        tests++;
        $display("[TB] mid-run reset checked");
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_wrap();
        test_recover();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
